// File: rtl/serial_feeder_pkg.sv
// serial_feeder_pkg: shared state encoding and widths for the serial bit feeder
package serial_feeder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;
  localparam int GAP_W = 4;
endpackage

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: parallel-in serial-out register; the first bit is taken by the caller at load time
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_bit
);
  logic [WIDTH-1:0] shreg_q, shreg_d, src;
  // Load stores the word already advanced by one, so q_bit is always the next bit to emit
  always_comb begin
    src     = load ? d : shreg_q;
    shreg_d = (load | shift) ? (MSB_FIRST ? src << 1 : src >> 1) : shreg_q;
  end
  // Register with synchronous active-low clear
  always_ff @(posedge clk) begin
    shreg_q <= !rst ? '0 : shreg_d;
  end
  assign q_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
endmodule

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: valid/ready word intake serialised onto x/x_valid with optional idle gap and stall
module serial_bit_feeder
  import serial_feeder_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             hold,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);
  localparam int BW = $clog2(WIDTH);
  state_t           state_q, state_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [GAP_W-1:0] gapcnt_q, gapcnt_d;
  logic             x_q, x_d;
  logic             last, accept, advance, q_bit;
  assign last      = bitcnt_q == '0;
  assign x_valid   = (state_q == ST_SHIFT) & ~hold;
  assign word_done = last & x_valid;
  assign din_ready = rst & ((state_q == ST_IDLE) | (word_done & (GAP == 0)));
  assign accept    = din_valid & din_ready;
  assign advance   = x_valid & ~last;
  assign busy      = state_q != ST_IDLE;
  assign x         = x_q;
  piso_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .shift(advance),
    .d    (din),
    .q_bit(q_bit)
  );
  // Next state: a load wins, then end-of-word, then a bit advance, then the gap countdown
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    x_d      = x_q;
    if (accept) begin
      state_d  = ST_SHIFT;
      bitcnt_d = BW'(WIDTH - 1);
      x_d      = MSB_FIRST ? din[WIDTH-1] : din[0];
    end else if (word_done) begin
      state_d  = GAP > 0 ? ST_GAP : ST_IDLE;
      gapcnt_d = GAP_W'(GAP > 0 ? GAP - 1 : 0);
    end else if (advance) begin
      bitcnt_d = bitcnt_q - 1'b1;
      x_d      = q_bit;
    end else if (state_q == ST_GAP) begin
      state_d  = gapcnt_q == '0 ? ST_IDLE : ST_GAP;
      gapcnt_d = gapcnt_q == '0 ? gapcnt_q : gapcnt_q - 1'b1;
    end
  end
  // State registers with synchronous active-low reset that discards any word in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      x_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      x_q      <= x_d;
    end
  end
endmodule
